// File: rtl/debug_loader_pkg.sv
// Shared command bytes, FSM state encoding and helpers for the debug byte-stream loader.
package debug_loader_pkg;

  localparam logic [7:0] CMD_WR_INST = 8'h01;
  localparam logic [7:0] CMD_WR_DATA = 8'h02;
  localparam logic [7:0] CMD_RD_DATA = 8'h03;
  localparam logic [7:0] CMD_RUN     = 8'h04;
  localparam logic [7:0] CMD_HALT    = 8'h05;

  // ADDR (4 bytes) + LEN (2 bytes) following the command byte
  localparam int HDR_BYTES = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    RADDR,
    TX,
    CHK
  } state_t;

  function automatic logic is_xfer_cmd(input logic [7:0] c);
    return (c == CMD_WR_INST) || (c == CMD_WR_DATA) || (c == CMD_RD_DATA);
  endfunction

  function automatic logic [31:0] next_word_addr(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/debug_loader_byte_word_packer.sv
// Little-endian 4-byte word assembler (push) and serializer (load/pop) sharing one register.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        load,
  input  logic        pop,
  input  logic [7:0]  byte_in,
  input  logic [31:0] word_in,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [1:0] idx;

  // First byte pushed ends up in word[7:0]; pop emits word[7:0] first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= 32'h0;
      idx  <= 2'd0;
    end else if (clr) begin
      idx <= 2'd0;
    end else if (load) begin
      word <= word_in;
      idx  <= 2'd0;
    end else if (push) begin
      word <= {byte_in, word[31:8]};
      idx  <= idx + 2'd1;
    end else if (pop) begin
      word <= {8'h00, word[31:8]};
      idx  <= idx + 2'd1;
    end
  end

  assign byte_out = word[7:0];
  assign last     = (idx == 2'd3);

endmodule

// File: rtl/debug_loader.sv
// Host byte-link program loader driving the core's debug cache ports and core_hold.
// Optional per-frame XOR checksum byte enabled by defining DEBUG_LOADER_CHECKSUM_EN.
module debug_loader
  import debug_loader_pkg::*;
#(
  parameter int   RD_LATENCY    = 1,
  parameter int   LEN_W         = 16,
  parameter logic HOLD_ON_RESET = 1'b1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] dbg_i_addr,
  output logic [31:0] dbg_i_wd,
  output logic [3:0]  dbg_i_we,
  output logic [31:0] dbg_d_addr,
  output logic [31:0] dbg_d_wd,
  output logic [3:0]  dbg_d_we,
  input  logic [31:0] dbg_d_rd,
  output logic        core_hold,
  output logic        busy,
  output logic        err
);

  state_t           state, state_d;
  logic [31:0]      addr;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       cmd;
  logic [2:0]       hdr_idx;
  logic [7:0]       len_lo;
  logic [1:0]       lat_cnt;
  logic             suppress;
`ifdef DEBUG_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic        rx_acc, tx_fire, hdr_last, cnt_last, lat_done, len_zero, wr_en;
  logic        pk_clr, pk_push, pk_load, pk_pop, pk_last;
  logic [31:0] pk_word;
  logic [7:0]  pk_byte;

  assign rx_ready = (state == IDLE) || (state == HDR) || (state == DATA) || (state == CHK);
  assign rx_acc   = rx_valid & rx_ready;
  assign tx_valid = (state == TX);
  assign tx_data  = pk_byte;
  assign tx_fire  = tx_valid & tx_ready;
  assign busy     = (state != IDLE);

  assign hdr_last = (hdr_idx == 3'(HDR_BYTES - 1));
  assign cnt_last = (cnt == LEN_W'(1));
  assign lat_done = (lat_cnt == 2'(RD_LATENCY));
  assign len_zero = ({rx_data, len_lo} == 16'h0);

  assign pk_clr  = (state == IDLE) && rx_acc;
  assign pk_push = (state == DATA) && rx_acc;
  assign pk_load = (state == RADDR) && lat_done;
  assign pk_pop  = (state == TX) && tx_fire;

  byte_word_packer u_packer (
    .clk     (CPU_CLK),
    .rst_n   (CPU_RST),
    .clr     (pk_clr),
    .push    (pk_push),
    .load    (pk_load),
    .pop     (pk_pop),
    .byte_in (rx_data),
    .word_in (dbg_d_rd),
    .word    (pk_word),
    .byte_out(pk_byte),
    .last    (pk_last)
  );

  // A frame started while the core runs is consumed but never written.
  assign wr_en      = (state == WRITE) && !suppress;
  assign dbg_i_we   = (wr_en && cmd == CMD_WR_INST) ? 4'hF : 4'h0;
  assign dbg_d_we   = (wr_en && cmd == CMD_WR_DATA) ? 4'hF : 4'h0;
  assign dbg_i_addr = addr;
  assign dbg_d_addr = addr;
  assign dbg_i_wd   = pk_word;
  assign dbg_d_wd   = pk_word;

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_xfer_cmd(rx_data)) state_d = HDR;
`ifdef DEBUG_LOADER_CHECKSUM_EN
          else if (rx_data == CMD_RUN || rx_data == CMD_HALT) state_d = CHK;
`endif
        end
      end
      HDR: begin
        if (rx_valid && hdr_last) begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
          if (!len_zero && cmd != CMD_RD_DATA) state_d = DATA;
          else                                 state_d = CHK;
`else
          if (len_zero)                 state_d = IDLE;
          else if (cmd == CMD_RD_DATA)  state_d = RADDR;
          else                          state_d = DATA;
`endif
        end
      end
      DATA: begin
        if (rx_valid && pk_last) state_d = WRITE;
      end
      WRITE: begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
        state_d = cnt_last ? CHK : DATA;
`else
        state_d = cnt_last ? IDLE : DATA;
`endif
      end
      RADDR: begin
        if (lat_done) state_d = TX;
      end
      TX: begin
        if (tx_fire && pk_last) state_d = cnt_last ? IDLE : RADDR;
      end
`ifdef DEBUG_LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_valid) state_d = (cmd == CMD_RD_DATA && cnt != '0) ? RADDR : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      addr      <= 32'h0;
      cnt       <= '0;
      cmd       <= 8'h0;
      hdr_idx   <= 3'd0;
      len_lo    <= 8'h0;
      lat_cnt   <= 2'd0;
      suppress  <= 1'b0;
      err       <= 1'b0;
      core_hold <= HOLD_ON_RESET;
`ifdef DEBUG_LOADER_CHECKSUM_EN
      csum      <= 8'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (rx_acc) begin
            err     <= 1'b0;
            cmd     <= rx_data;
            hdr_idx <= 3'd0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum    <= rx_data;
`endif
            if (is_xfer_cmd(rx_data)) begin
              suppress <= ~core_hold;
              if (!core_hold) err <= 1'b1;
            end else if (rx_data == CMD_RUN) begin
`ifndef DEBUG_LOADER_CHECKSUM_EN
              core_hold <= 1'b0;
`endif
            end else if (rx_data == CMD_HALT) begin
`ifndef DEBUG_LOADER_CHECKSUM_EN
              core_hold <= 1'b1;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (rx_acc) begin
            hdr_idx <= hdr_idx + 3'd1;
`ifdef DEBUG_LOADER_CHECKSUM_EN
            csum    <= csum ^ rx_data;
`endif
            if (hdr_idx < 3'd4)       addr   <= {rx_data, addr[31:8]};
            else if (hdr_idx == 3'd4) len_lo <= rx_data;
            else                      cnt    <= LEN_W'({rx_data, len_lo});
          end
        end
        DATA: begin
`ifdef DEBUG_LOADER_CHECKSUM_EN
          if (rx_acc) csum <= csum ^ rx_data;
`endif
        end
        WRITE: begin
          addr <= next_word_addr(addr);
          cnt  <= cnt - LEN_W'(1);
        end
        RADDR: begin
          lat_cnt <= lat_done ? 2'd0 : lat_cnt + 2'd1;
        end
        TX: begin
          if (tx_fire && pk_last) begin
            addr <= next_word_addr(addr);
            cnt  <= cnt - LEN_W'(1);
          end
        end
`ifdef DEBUG_LOADER_CHECKSUM_EN
        // A corrupted frame must never release the core.
        CHK: begin
          if (rx_acc) begin
            if (rx_data != csum) begin
              err       <= 1'b1;
              core_hold <= 1'b1;
            end else if (cmd == CMD_RUN) begin
              core_hold <= 1'b0;
            end else if (cmd == CMD_HALT) begin
              core_hold <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Directed self-checking bench for debug_loader with a small debug-port memory model.
module tb_debug_loader;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] dbg_i_addr, dbg_i_wd, dbg_d_addr, dbg_d_wd;
  logic [3:0]  dbg_i_we, dbg_d_we;
  logic [31:0] dbg_d_rd = 32'h0;
  logic        core_hold, busy, err;

  int checks = 0;
  int errors = 0;
  logic [7:0] tb_csum = 8'h0;

  logic [31:0] dmem [0:255];
  logic [31:0] iw_a [0:15];
  logic [31:0] iw_d [0:15];
  logic [31:0] dw_a [0:15];
  logic [31:0] dw_d [0:15];
  int iw_n = 0;
  int dw_n = 0;
  int viol = 0;

  debug_loader dut (
    .CPU_CLK   (CPU_CLK),
    .CPU_RST   (CPU_RST),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dbg_i_addr(dbg_i_addr),
    .dbg_i_wd  (dbg_i_wd),
    .dbg_i_we  (dbg_i_we),
    .dbg_d_addr(dbg_d_addr),
    .dbg_d_wd  (dbg_d_wd),
    .dbg_d_we  (dbg_d_we),
    .dbg_d_rd  (dbg_d_rd),
    .core_hold (core_hold),
    .busy      (busy),
    .err       (err)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Write logger and port-rule monitor
  always @(posedge CPU_CLK) begin
    if (dbg_i_we != 4'h0) begin
      iw_a[iw_n % 16] = dbg_i_addr;
      iw_d[iw_n % 16] = dbg_i_wd;
      iw_n = iw_n + 1;
    end
    if (dbg_d_we != 4'h0) begin
      dw_a[dw_n % 16] = dbg_d_addr;
      dw_d[dw_n % 16] = dbg_d_wd;
      dw_n = dw_n + 1;
    end
    if ((dbg_i_we != 4'h0 && dbg_d_we != 4'h0) ||
        (dbg_i_we != 4'h0 && dbg_i_we != 4'hF) ||
        (dbg_d_we != 4'h0 && dbg_d_we != 4'hF))
      viol = viol + 1;
  end

  // Data cache model: one-cycle registered read
  always @(posedge CPU_CLK) begin
    if (dbg_d_we == 4'hF) dmem[dbg_d_addr[9:2]] <= dbg_d_wd;
    dbg_d_rd <= dmem[dbg_d_addr[9:2]];
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge CPU_CLK);
      n++;
    end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_accept_timeout rx_ready=%b required 1", rx_ready);
    end
    @(posedge CPU_CLK); #1;
    rx_valid = 1'b0;
    tb_csum  = tb_csum ^ b;
    @(negedge CPU_CLK);
  endtask

  task automatic frame_end;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    send_byte(tb_csum);
`endif
  endtask

  task automatic send_hdr(input logic [7:0] c, input logic [31:0] a, input logic [15:0] len);
    tb_csum = 8'h0;
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge CPU_CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic recv_word(output logic [31:0] w, input bit toggle);
    int got, n;
    logic [7:0] held;
    bit stalled, r;
    got = 0; n = 0; stalled = 0; r = 1; held = 8'h0; w = 32'h0;
    while (got < 4 && n < 200) begin
      @(negedge CPU_CLK);
      n++;
      tx_ready = toggle ? r : 1'b1;
      r = ~r;
      if (tx_valid) begin
        if (stalled) begin
          checks++;
          if (tx_data !== held) begin
            errors++;
            $display("FAIL tx_stable tx_data=%h required %h", tx_data, held);
          end
        end
        if (tx_ready) begin
          w[got*8 +: 8] = tx_data;
          got++;
          stalled = 0;
        end else begin
          held = tx_data;
          stalled = 1;
        end
      end
    end
    if (got < 4) begin
      checks++; errors++;
      $display("FAIL tx_timeout bytes=%0d required 4", got);
    end
    @(negedge CPU_CLK);
    tx_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %b want 1", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL rst_core_hold got %b want 1", core_hold); end
    checks++; if (dbg_i_we !== 4'h0 || dbg_d_we !== 4'h0) begin errors++; $display("FAIL rst_we got %h/%h want 0/0", dbg_i_we, dbg_d_we); end
    checks++; if (dbg_i_addr !== 32'h0 || dbg_d_wd !== 32'h0) begin errors++; $display("FAIL rst_addr_wd got %h/%h want 0/0", dbg_i_addr, dbg_d_wd); end
  endtask

  task automatic test_wr_inst;
    int b;
    b = iw_n;
    send_hdr(8'h01, 32'h0, 16'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
    frame_end();
    wait_idle();
    checks++; if (iw_n - b !== 2) begin errors++; $display("FAIL wr_inst_count got %0d want 2", iw_n - b); end
    checks++; if (iw_a[b % 16] !== 32'h0 || iw_d[b % 16] !== 32'h00000013) begin errors++; $display("FAIL wr_inst_w0 got %h:%h want 00000000:00000013", iw_a[b % 16], iw_d[b % 16]); end
    checks++; if (iw_a[(b+1) % 16] !== 32'h4 || iw_d[(b+1) % 16] !== 32'h00100093) begin errors++; $display("FAIL wr_inst_w1 got %h:%h want 00000004:00100093", iw_a[(b+1) % 16], iw_d[(b+1) % 16]); end
  endtask

  task automatic test_wr_rd_data;
    int b;
    logic [31:0] w;
    b = dw_n;
    send_hdr(8'h02, 32'h100, 16'd1);
    send_word(32'hDEADBEEF);
    frame_end();
    wait_idle();
    checks++; if (dw_n - b !== 1) begin errors++; $display("FAIL wr_data_count got %0d want 1", dw_n - b); end
    checks++; if (dw_a[b % 16] !== 32'h100 || dw_d[b % 16] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data_w0 got %h:%h want 00000100:deadbeef", dw_a[b % 16], dw_d[b % 16]); end
    send_hdr(8'h03, 32'h100, 16'd1);
    frame_end();
    recv_word(w, 1'b1);
    checks++; if (w !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", w); end
    wait_idle();
  endtask

  task automatic test_addr_wrap;
    int b;
    b = dw_n;
    send_hdr(8'h02, 32'hFFFFFFFC, 16'd2);
    send_word(32'h11111111);
    send_word(32'h22222222);
    frame_end();
    wait_idle();
    checks++; if (dw_n - b !== 2) begin errors++; $display("FAIL wrap_count got %0d want 2", dw_n - b); end
    checks++; if (dw_a[b % 16] !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_a0 got %h want fffffffc", dw_a[b % 16]); end
    checks++; if (dw_a[(b+1) % 16] !== 32'h0 || dw_d[(b+1) % 16] !== 32'h22222222) begin errors++; $display("FAIL wrap_a1 got %h:%h want 00000000:22222222", dw_a[(b+1) % 16], dw_d[(b+1) % 16]); end
  endtask

  task automatic test_len_zero;
    int b;
    b = iw_n;
    send_hdr(8'h01, 32'h40, 16'd0);
    frame_end();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy got %b want 0", busy); end
    checks++; if (iw_n - b !== 0) begin errors++; $display("FAIL len0_writes got %0d want 0", iw_n - b); end
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h7F);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcmd_err got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy got %b want 0", busy); end
    tb_csum = 8'h0;
    send_byte(8'h05);
    frame_end();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL badcmd_clear got %b want 0", err); end
  endtask

  task automatic test_run_halt;
    int b;
    logic [7:0] last_b;
    tb_csum = 8'h0;
`ifdef DEBUG_LOADER_CHECKSUM_EN
    send_byte(8'h04);
    last_b = tb_csum;
`else
    last_b = 8'h04;
`endif
    rx_data = last_b;
    rx_valid = 1'b1;
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL run_hold_before got %b want 1", core_hold); end
    @(posedge CPU_CLK); #1;
    rx_valid = 1'b0;
    checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL run_hold_after got %b want 0", core_hold); end
    @(negedge CPU_CLK);
    b = iw_n;
    send_hdr(8'h01, 32'h20, 16'd1);
    send_word(32'h00000013);
    frame_end();
    wait_idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL running_wr_err got %b want 1", err); end
    checks++; if (iw_n - b !== 0) begin errors++; $display("FAIL running_wr_pulses got %0d want 0", iw_n - b); end
    tb_csum = 8'h0;
    send_byte(8'h05);
    frame_end();
    checks++; if (core_hold !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL halt got hold=%b err=%b want 1/0", core_hold, err); end
  endtask

`ifdef DEBUG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    send_byte(8'h04);
    send_byte(8'h00);
    checks++; if (err !== 1'b1 || core_hold !== 1'b1) begin errors++; $display("FAIL csum_bad got err=%b hold=%b want 1/1", err, core_hold); end
    send_byte(8'h04);
    send_byte(8'h04);
    checks++; if (err !== 1'b0 || core_hold !== 1'b0) begin errors++; $display("FAIL csum_good got err=%b hold=%b want 0/0", err, core_hold); end
    send_byte(8'h05);
    send_byte(8'h05);
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL csum_halt got %b want 1", core_hold); end
  endtask
`endif

  task automatic test_reset_midframe;
    int bi, bd;
    bi = iw_n;
    bd = dw_n;
    send_hdr(8'h02, 32'h200, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy); end
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);
    checks++; if (iw_n - bi !== 0 || dw_n - bd !== 0) begin errors++; $display("FAIL midframe_writes got %0d/%0d want 0/0", iw_n - bi, dw_n - bd); end
    checks++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL midframe_idle got busy=%b rdy=%b want 0/1", busy, rx_ready); end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL midframe_hold got %b want 1", core_hold); end
  endtask

  task automatic test_port_rules;
    checks++; if (viol !== 0) begin errors++; $display("FAIL we_rules got %0d violations want 0", viol); end
  endtask

  initial begin
    repeat (3) @(negedge CPU_CLK);
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);
    test_reset();
    test_wr_inst();
    test_wr_rd_data();
    test_addr_wrap();
    test_len_zero();
    test_bad_cmd();
    test_run_halt();
`ifdef DEBUG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midframe();
    test_port_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
